// File: rtl/rf_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// the hardwired-zero register address and the pending-count width helper.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;
  localparam int R0_ADDR    = 0;

  // One extra bit so the count can represent "all registers pending".
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with incremental pending count, sticky protocol
// error flag and the busy lookup for both read ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = cnt_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              err,
  output logic [CNT_W-1:0]  pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_nxt;
  logic             iss_ok;
  logic             wr_ok;
  logic             same_dst;
  logic             inc;
  logic             dec;
  logic             err_now;

  // r0 neither becomes pending nor counts as an orphan writeback.
  assign iss_ok   = issue_en && !(ZERO_REG != 0 && issue_addr == ADDR_W'(R0_ADDR));
  assign wr_ok    = wr_en && !(ZERO_REG != 0 && wr_addr == ADDR_W'(R0_ADDR));
  assign same_dst = wr_en && (wr_addr == issue_addr);

  assign inc = iss_ok && !pend_q[issue_addr];
  assign dec = wr_ok && pend_q[wr_addr] && !(iss_ok && wr_addr == issue_addr);

  assign err_now = (iss_ok && pend_q[issue_addr] && !same_dst) ||
                   (wr_ok && !pend_q[wr_addr]);

  always_comb begin
    pend_nxt = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)
        pend_nxt[r] = 1'b0;
      else if (iss_ok && issue_addr == ADDR_W'(r))
        pend_nxt[r] = 1'b1;
      else if (wr_ok && wr_addr == ADDR_W'(r))
        pend_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      if (flush)
        pend_cnt <= '0;
      else
        pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec);
      if (!flush && err_now)
        err <= 1'b1;
    end
  end

  // A writeback in the same cycle bypasses its data, so the reader is not blocked.
  assign rd_busy1 = rst_n && pend_q[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
  assign rd_busy2 = rst_n && pend_q[rd_addr2] && !(wr_en && wr_addr == rd_addr2);

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-through bypass and a pending
// scoreboard for ID-stage hazard detection.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              err,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ADDR_W'(R0_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG != 0 && addr == ADDR_W'(R0_ADDR))
      return '0;
    else if (wr_en && wr_addr == addr)
      return wr_data;
    else
      return regs[addr];
  endfunction

  // Gate with reset so an active bypass cannot leak data while held in reset.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rst_n) begin
      rd_data1 = read_port(rd_addr1);
      rd_data2 = read_port(rd_addr2);
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (ADDR_W + 1)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_busy1   (rd_busy1),
    .rd_busy2   (rd_busy2),
    .err        (err),
    .pend_cnt   (pend_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, scoreboard counting, r0 handling,
// flush, sticky error and asynchronous reset.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, issue_addr, wr_addr;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        rd_busy1, rd_busy2, issue_en, wr_en, flush, err;
  logic [5:0]  pend_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_busy1   (rd_busy1),
    .rd_addr2   (rd_addr2),
    .rd_data2   (rd_data2),
    .rd_busy2   (rd_busy2),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .err        (err),
    .pend_cnt   (pend_cnt)
  );

  task automatic idle();
    issue_en = 1'b0;
    wr_en    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    issue_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_addr1 = 5'd5; rd_addr2 = 5'd31;
    #12;
    n_total++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", rd_data1, rd_data2);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_total++;
    if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0)
      $display("FAIL reset_busy: got %b/%b want 0/0", rd_busy1, rd_busy2);
    else n_pass++;
    n_total++;
    if (pend_cnt !== 6'd0 || err !== 1'b0)
      $display("FAIL reset_cnt_err: got cnt=%0d err=%b want 0/0", pend_cnt, err);
    else n_pass++;
  endtask

  task automatic test_issue_writeback();
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd3; rd_addr1 = 5'd3;
    @(posedge clk); #1;
    n_total++;
    if (rd_busy1 !== 1'b1 || pend_cnt !== 6'd1)
      $display("FAIL issue_r3: got busy=%b cnt=%0d want 1/1", rd_busy1, pend_cnt);
    else n_pass++;
    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; #1;
    n_total++;
    if (rd_data1 !== 32'hDEADBEEF || rd_busy1 !== 1'b0)
      $display("FAIL bypass_r3: got data=%h busy=%b want deadbeef/0", rd_data1, rd_busy1);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (pend_cnt !== 6'd0 || err !== 1'b0)
      $display("FAIL wb_r3_cnt: got cnt=%0d err=%b want 0/0", pend_cnt, err);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_total++;
    if (rd_data1 !== 32'hDEADBEEF)
      $display("FAIL stored_r3: got %h want deadbeef", rd_data1);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd7; rd_addr2 = 5'd7;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12; #1;
    n_total++;
    if (rd_data2 !== 32'h12 || rd_busy2 !== 1'b0)
      $display("FAIL same_bypass: got data=%h busy=%b want 12/0", rd_data2, rd_busy2);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (pend_cnt !== 6'd1 || err !== 1'b0)
      $display("FAIL same_cnt: got cnt=%0d err=%b want 1/0", pend_cnt, err);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_total++;
    if (rd_busy2 !== 1'b1 || rd_data2 !== 32'h12)
      $display("FAIL same_pend: got busy=%b data=%h want 1/12", rd_busy2, rd_data2);
    else n_pass++;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    @(negedge clk); idle(); #1;
    n_total++;
    if (pend_cnt !== 6'd0 || rd_busy2 !== 1'b0)
      $display("FAIL r7_clear: got cnt=%0d busy=%b want 0/0", pend_cnt, rd_busy2);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 5'd0; rd_addr1 = 5'd0; #1;
    n_total++;
    if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0)
      $display("FAIL r0_bypass: got data=%h busy=%b want 0/0", rd_data1, rd_busy1);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_total++;
    if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0 || pend_cnt !== 6'd0 || err !== 1'b0)
      $display("FAIL r0_after: got data=%h busy=%b cnt=%0d err=%b want 0/0/0/0",
               rd_data1, rd_busy1, pend_cnt, err);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [4:0] dst [3];
    dst[0] = 5'd4; dst[1] = 5'd9; dst[2] = 5'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue_en = 1'b1; issue_addr = dst[i];
    end
    @(negedge clk); idle(); #1;
    n_total++;
    if (pend_cnt !== 6'd3)
      $display("FAIL three_pend: got cnt=%0d want 3", pend_cnt);
    else n_pass++;
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd2;
    @(negedge clk); idle();
    rd_addr1 = 5'd4; rd_addr2 = 5'd2; #1;
    n_total++;
    if (pend_cnt !== 6'd0 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0 || err !== 1'b0)
      $display("FAIL flush: got cnt=%0d busy=%b/%b err=%b want 0/0/0/0",
               pend_cnt, rd_busy1, rd_busy2, err);
    else n_pass++;
    rd_addr1 = 5'd3; rd_addr2 = 5'd7; #1;
    n_total++;
    if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'h12)
      $display("FAIL flush_data: got %h/%h want deadbeef/12", rd_data1, rd_data2);
    else n_pass++;
  endtask

  task automatic test_err_double_issue();
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd6;
    @(negedge clk); #1;
    n_total++;
    if (err !== 1'b0)
      $display("FAIL first_issue_err: got %b want 0", err);
    else n_pass++;
    @(negedge clk); idle(); #1;
    n_total++;
    if (err !== 1'b1)
      $display("FAIL double_issue_err: got %b want 1", err);
    else n_pass++;
    flush = 1'b1;
    @(negedge clk); idle(); #1;
    n_total++;
    if (err !== 1'b1 || pend_cnt !== 6'd0)
      $display("FAIL err_sticky: got err=%b cnt=%0d want 1/0", err, pend_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
    issue_en = 1'b1; issue_addr = 5'd10;
    rd_addr1 = 5'd3; rd_addr2 = 5'd5;
    #2 rst_n = 1'b0; #1;
    n_total++;
    if (err !== 1'b0 || pend_cnt !== 6'd0)
      $display("FAIL async_rst_state: got err=%b cnt=%0d want 0/0", err, pend_cnt);
    else n_pass++;
    n_total++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
      $display("FAIL async_rst_data: got %h/%h want 0/0", rd_data1, rd_data2);
    else n_pass++;
    @(negedge clk); idle(); rst_n = 1'b1;
    rd_addr1 = 5'd10; #1;
    n_total++;
    if (rd_data2 !== 32'h0 || rd_busy1 !== 1'b0)
      $display("FAIL post_rst: got r5=%h busy10=%b want 0/0", rd_data2, rd_busy1);
    else n_pass++;
  endtask

  task automatic test_err_orphan();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55; rd_addr1 = 5'd8;
    @(negedge clk); idle(); #1;
    n_total++;
    if (err !== 1'b1)
      $display("FAIL orphan_err: got %b want 1", err);
    else n_pass++;
    n_total++;
    if (rd_data1 !== 32'h55 || pend_cnt !== 6'd0)
      $display("FAIL orphan_data: got data=%h cnt=%0d want 55/0", rd_data1, pend_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_issue_writeback();
    test_same_cycle();
    test_zero_reg();
    test_flush();
    test_err_double_issue();
    test_async_reset();
    test_err_orphan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
